// File: rtl/adc_capture_pkg.sv
// Shared constants and types for the ADC capture peripheral.
// Register map, CTRL/STATUS bit positions and the capture FSM state encoding.
package adc_capture_pkg;

  localparam int unsigned AVS_ADDR_W = 2;
  localparam int unsigned AVS_DATA_W = 32;
  localparam int unsigned TIMEOUT_W  = 16;

  localparam logic [AVS_ADDR_W-1:0] ADDR_CTRL    = 2'd0;
  localparam logic [AVS_ADDR_W-1:0] ADDR_STATUS  = 2'd1;
  localparam logic [AVS_ADDR_W-1:0] ADDR_DATA    = 2'd2;
  localparam logic [AVS_ADDR_W-1:0] ADDR_TIMEOUT = 2'd3;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_ADC_RST = 2;
  localparam int unsigned CTRL_CONT    = 3;

  localparam int unsigned ST_ACTIVE    = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_FULL      = 2;
  localparam int unsigned ST_OVERRUN   = 3;
  localparam int unsigned ST_TIMEOUT   = 4;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 4;

  typedef enum logic [2:0] {IDLE, ARM, TRIG, WAIT, ADCRST} state_e;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line between the interconnect and the ADC capture block.
interface adc_capture_ctrl_if;

  logic [adc_capture_pkg::AVS_ADDR_W-1:0] AVS_ADDRESS;
  logic                                   AVS_READ;
  logic                                   AVS_WRITE;
  logic [adc_capture_pkg::AVS_DATA_W-1:0] AVS_WRITEDATA;
  logic [adc_capture_pkg::AVS_DATA_W-1:0] AVS_READDATA;
  logic                                   IRQ;

  modport slave (
    input  AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA,
    output AVS_READDATA, IRQ
  );

  modport master (
    output AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA,
    input  AVS_READDATA, IRQ
  );

endinterface

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO; a pop frees a slot for a push in the same cycle, so push at full
// is accepted when paired with a pop. Pointers wrap naturally on a power-of-2 depth.
module adc_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         head_c,
  output logic                          full_c,
  output logic                          empty_c,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(FIFO_DEPTH));
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Avalon-MM ADC capture controller: drives ADC trigger/reset handshake, buffers samples
// in a FIFO and raises a level interrupt while samples are pending or a timeout occurred.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned RESET_CYCLES    = 4,
  parameter int unsigned TIMEOUT_DEFAULT = 500
) (
  input  logic                  CLK,
  input  logic                  RESET,
  adc_capture_ctrl_if.slave     avs,
  output logic                  ADC_TRIGGER,
  output logic                  ADC_RESET,
  input  logic [DATA_WIDTH-1:0] ADC_DATA,
  input  logic                  ADC_DVALID,
  input  logic                  ADC_BUSY
);

  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wait_cnt_q;
  logic [TIMEOUT_W-1:0]  timeout_q;
  logic [RCNT_W-1:0]     rcnt_q;
  logic                  irq_en_q, cont_q, overrun_q, tflag_q;
  logic [AVS_DATA_W-1:0] readdata_q;

  logic                  wr_ctrl_c, wr_status_c, start_c, adcrst_c, pop_c;
  logic                  push_c, wait_clr_c, wait_inc_c, to_set_c, rcnt_clr_c, rcnt_inc_c;
  logic [DATA_WIDTH-1:0] head_c;
  logic                  full_c, empty_c;
  logic [CW-1:0]         fifo_count;
  logic [AVS_DATA_W-1:0] rd_mux_c;
  logic                  unused_wdata;

  assign wr_ctrl_c   = avs.AVS_WRITE && (avs.AVS_ADDRESS == ADDR_CTRL);
  assign wr_status_c = avs.AVS_WRITE && (avs.AVS_ADDRESS == ADDR_STATUS);
  assign start_c     = wr_ctrl_c && avs.AVS_WRITEDATA[CTRL_START];
  assign adcrst_c    = wr_ctrl_c && avs.AVS_WRITEDATA[CTRL_ADC_RST];
  assign pop_c       = avs.AVS_READ && (avs.AVS_ADDRESS == ADDR_DATA) && !empty_c;
  assign unused_wdata = ^avs.AVS_WRITEDATA[AVS_DATA_W-1:TIMEOUT_W];

  adc_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (ADC_DATA),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (fifo_count)
  );

  // Next-state and control strobes; a DVALID in the expiry cycle wins over the timeout
  always_comb begin
    state_d    = state_q;
    push_c     = 1'b0;
    wait_clr_c = 1'b0;
    wait_inc_c = 1'b0;
    to_set_c   = 1'b0;
    rcnt_clr_c = 1'b0;
    rcnt_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (adcrst_c) begin
          state_d    = ADCRST;
          rcnt_clr_c = 1'b1;
        end else if (start_c) begin
          state_d = ARM;
        end
      end
      ARM:  if (!ADC_BUSY) state_d = TRIG;
      TRIG: begin
        wait_clr_c = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ADC_DVALID) begin
          push_c  = 1'b1;
          state_d = cont_q ? ARM : IDLE;
        end else if (wait_cnt_q >= timeout_q) begin
          to_set_c   = 1'b1;
          rcnt_clr_c = 1'b1;
          state_d    = ADCRST;
        end else begin
          wait_inc_c = 1'b1;
        end
      end
      ADCRST: begin
        if (rcnt_q == RCNT_W'(RESET_CYCLES - 1)) state_d = IDLE;
        else rcnt_inc_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      ADC_TRIGGER <= 1'b0;
      ADC_RESET   <= 1'b0;
      wait_cnt_q  <= '0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ADC_TRIGGER <= (state_d == TRIG);
      ADC_RESET   <= (state_d == ADCRST);
      if (wait_clr_c)      wait_cnt_q <= '0;
      else if (wait_inc_c) wait_cnt_q <= wait_cnt_q + TIMEOUT_W'(1);
      if (rcnt_clr_c)      rcnt_q <= '0;
      else if (rcnt_inc_c) rcnt_q <= rcnt_q + RCNT_W'(1);
    end
  end

  // Software registers and sticky flags; a set in the same cycle as a W1C wins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_en_q  <= 1'b0;
      cont_q    <= 1'b0;
      timeout_q <= TIMEOUT_W'(TIMEOUT_DEFAULT);
      overrun_q <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        irq_en_q <= avs.AVS_WRITEDATA[CTRL_IRQ_EN];
        cont_q   <= avs.AVS_WRITEDATA[CTRL_CONT];
      end
      if (avs.AVS_WRITE && (avs.AVS_ADDRESS == ADDR_TIMEOUT))
        timeout_q <= avs.AVS_WRITEDATA[TIMEOUT_W-1:0];
      if (push_c && full_c && !pop_c)                           overrun_q <= 1'b1;
      else if (wr_status_c && avs.AVS_WRITEDATA[ST_OVERRUN])    overrun_q <= 1'b0;
      if (to_set_c)                                             tflag_q <= 1'b1;
      else if (wr_status_c && avs.AVS_WRITEDATA[ST_TIMEOUT])    tflag_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (avs.AVS_ADDRESS)
      ADDR_CTRL: begin
        rd_mux_c[CTRL_IRQ_EN] = irq_en_q;
        rd_mux_c[CTRL_CONT]   = cont_q;
      end
      ADDR_STATUS: begin
        rd_mux_c[ST_ACTIVE]  = (state_q != IDLE);
        rd_mux_c[ST_EMPTY]   = empty_c;
        rd_mux_c[ST_FULL]    = full_c;
        rd_mux_c[ST_OVERRUN] = overrun_q;
        rd_mux_c[ST_TIMEOUT] = tflag_q;
        rd_mux_c[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
      end
      ADDR_DATA:    rd_mux_c = empty_c ? '0 : AVS_DATA_W'(head_c);
      ADDR_TIMEOUT: rd_mux_c = AVS_DATA_W'(timeout_q);
      default:      rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) readdata_q <= '0;
    else       readdata_q <= avs.AVS_READ ? rd_mux_c : '0;
  end

  assign avs.AVS_READDATA = readdata_q;
  // Pure decode of flops so the line tracks the FIFO/flag state in the same cycle
  assign avs.IRQ = irq_en_q && (!empty_c || tflag_q);

endmodule
